// File: rtl/vga_cell_fb.sv
// Character-cell framebuffer: glyph writes over valid/ready, hardware clear,
// one-row circular scroll and a 2-cycle pixel read pipeline.
module vga_cell_fb #(
  parameter int unsigned H_RES  = 640,
  parameter int unsigned V_RES  = 480,
  parameter int unsigned CELL_W = 8,
  parameter int unsigned CELL_H = 16,
  localparam int unsigned W_COLS = H_RES / CELL_W,
  localparam int unsigned W_ROWS = V_RES / CELL_H,
  localparam int unsigned CW     = $clog2(W_COLS),
  localparam int unsigned RW     = $clog2(W_ROWS),
  localparam int unsigned XW     = $clog2(H_RES),
  localparam int unsigned YW     = $clog2(V_RES)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     w_valid,
  output logic                     w_ready,
  input  logic [CELL_W*CELL_H-1:0] w_data,
  input  logic [CW-1:0]            w_col,
  input  logic [RW-1:0]            w_row,
  input  logic                     clr_req,
  input  logic [CELL_W-1:0]        clr_val,
  input  logic                     scroll_req,
  output logic                     busy,
  input  logic                     rd,
  input  logic [XW-1:0]            r_x,
  input  logic [YW-1:0]            r_y,
  output logic                     out,
  output logic                     out_valid
);

  localparam int unsigned TOT  = V_RES * W_COLS;
  localparam int unsigned ROWW = CELL_H * W_COLS;
  localparam int unsigned AW   = $clog2(TOT);
  localparam int unsigned BW   = $clog2(CELL_W);

  typedef enum logic [1:0] {IDLE, WRITE, CLEAR, SCROLL} state_t;

  state_t                     r_state;
  logic [AW-1:0]              r_cnt;
  logic [RW-1:0]              r_top_row;
  logic [CELL_W-1:0]          r_fill;
  logic                       r_clr_pend;
  logic                       r_scr_pend;
  logic [CELL_W*CELL_H-1:0]   r_wdata;
  logic [CW-1:0]              r_wcol;
  logic [RW-1:0]              r_wrow;
  logic                       r_woor;

  logic [CELL_W-1:0]          r_mem [TOT];
  logic [CELL_W-1:0]          r_word;
  logic [BW-1:0]              r_bit;
  logic                       r_rv1;
  logic                       r_roor1;

  logic                       w_clr;
  logic                       w_scr;
  logic                       w_last;
  logic                       w_we;
  logic [AW-1:0]              w_waddr;
  logic [CELL_W-1:0]          w_wdata;
  logic                       w_roor;
  logic [RW-1:0]              w_rprow;
  logic [AW-1:0]              w_raddr;
  logic [BW-1:0]              w_rbit;

  // Logical text row to physical row: (t + top) mod W_ROWS, both operands < W_ROWS.
  function automatic logic [RW-1:0] f_phys(input logic [RW-1:0] t, input logic [RW-1:0] top);
    logic [RW:0] s;
    s = {1'b0, t} + {1'b0, top};
    if (32'(s) >= W_ROWS) s = s - (RW+1)'(W_ROWS);
    return s[RW-1:0];
  endfunction

  assign w_clr   = clr_req | r_clr_pend;
  assign w_scr   = scroll_req | r_scr_pend;
  assign busy    = (r_state != IDLE);
  assign w_ready = (r_state == IDLE) && !w_clr && !w_scr;

  // Write-port address/data and end-of-operation detect for the current state.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    w_last  = 1'b0;
    case (r_state)
      WRITE: begin
        w_we    = !r_woor;
        w_waddr = AW'((32'(r_wrow) * CELL_H + 32'(r_cnt)) * W_COLS + 32'(r_wcol));
        w_wdata = r_wdata[32'(r_cnt) * CELL_W +: CELL_W];
        w_last  = (32'(r_cnt) == CELL_H - 1);
      end
      CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_cnt;
        w_wdata = r_fill;
        w_last  = (32'(r_cnt) == TOT - 1);
      end
      SCROLL: begin
        w_we    = 1'b1;
        w_waddr = AW'(32'(r_top_row) * ROWW + 32'(r_cnt));
        w_wdata = '0;
        w_last  = (32'(r_cnt) == ROWW - 1);
      end
      default: ;
    endcase
  end

  // Control FSM: request arbitration, pending flags, counters and row pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= CLEAR;
      r_cnt      <= '0;
      r_top_row  <= '0;
      r_fill     <= '0;
      r_clr_pend <= 1'b0;
      r_scr_pend <= 1'b0;
      r_wdata    <= '0;
      r_wcol     <= '0;
      r_wrow     <= '0;
      r_woor     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_clr) begin
            r_state    <= CLEAR;
            r_fill     <= clr_val;
            r_clr_pend <= 1'b0;
            r_scr_pend <= 1'b0;
          end else if (w_scr) begin
            r_state    <= SCROLL;
            r_scr_pend <= 1'b0;
          end else if (w_valid) begin
            r_state <= WRITE;
            r_wdata <= w_data;
            r_wcol  <= w_col;
            r_wrow  <= f_phys(w_row, r_top_row);
            r_woor  <= (32'(w_col) >= W_COLS) || (32'(w_row) >= W_ROWS);
          end
        end
        default: begin
          if (clr_req)    r_clr_pend <= 1'b1;
          if (scroll_req) r_scr_pend <= 1'b1;
          if (w_last) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            if (r_state == CLEAR) r_top_row <= '0;
            if (r_state == SCROLL)
              r_top_row <= (32'(r_top_row) == W_ROWS - 1) ? '0 : r_top_row + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Read address: pixel to (physical line, column) word plus bit index.
  always_comb begin
    w_roor  = (32'(r_x) >= H_RES) || (32'(r_y) >= V_RES);
    w_rprow = f_phys(RW'(32'(r_y) / CELL_H), r_top_row);
    w_raddr = AW'((32'(w_rprow) * CELL_H + 32'(r_y) % CELL_H) * W_COLS + 32'(r_x) / CELL_W);
    w_rbit  = BW'(32'(r_x) % CELL_W);
    if (w_roor) w_raddr = '0;
  end

  // Memory: one write port, one registered read port (read-first on collision).
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
    r_word <= r_mem[w_raddr];
  end

  // Read pipeline stage 1 qualifiers and stage 2 pixel output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rv1     <= 1'b0;
      r_roor1   <= 1'b0;
      r_bit     <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      r_rv1     <= rd;
      r_roor1   <= w_roor;
      r_bit     <= w_rbit;
      out       <= r_rv1 && !r_roor1 && r_word[r_bit];
      out_valid <= r_rv1;
    end
  end

endmodule

// File: tb/tb_vga_cell_fb.sv
// Directed bench for vga_cell_fb on a reduced 96x80 geometry
// (12 columns x 5 text rows, 960 words, 192 words per text row).
module tb_vga_cell_fb;

  localparam int TOT  = 960;
  localparam int ROWW = 192;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         w_valid = 1'b0;
  logic         w_ready;
  logic [127:0] w_data = '0;
  logic [3:0]   w_col = '0;
  logic [2:0]   w_row = '0;
  logic         clr_req = 1'b0;
  logic [7:0]   clr_val = '0;
  logic         scroll_req = 1'b0;
  logic         busy;
  logic         rd = 1'b0;
  logic [6:0]   r_x = '0;
  logic [6:0]   r_y = '0;
  logic         out;
  logic         out_valid;

  int n_vec = 0;
  int n_err = 0;

  vga_cell_fb #(.H_RES(96), .V_RES(80), .CELL_W(8), .CELL_H(16)) dut (
    .clk(clk), .rst_n(rst_n), .w_valid(w_valid), .w_ready(w_ready),
    .w_data(w_data), .w_col(w_col), .w_row(w_row), .clr_req(clr_req),
    .clr_val(clr_val), .scroll_req(scroll_req), .busy(busy), .rd(rd),
    .r_x(r_x), .r_y(r_y), .out(out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 5000) begin
      tick();
      n++;
    end
  endtask

  task automatic read_px(input int x, input int y, output logic [1:0] res, output logic early);
    rd  = 1'b1;
    r_x = 7'(x);
    r_y = 7'(y);
    tick();
    early = out_valid;
    rd = 1'b0;
    tick();
    res = {out_valid, out};
  endtask

  task automatic px(input string tag, input int x, input int y, input logic e);
    logic [1:0] res;
    logic       early;
    read_px(x, y, res, early);
    chk(tag, 32'(res), {30'd0, 1'b1, e});
  endtask

  function automatic logic [127:0] glyph(input logic [7:0] b);
    logic [127:0] d;
    for (int k = 0; k < 16; k++) d[k*8 +: 8] = b;
    return d;
  endfunction

  task automatic start_write(input int col, input int row, input logic [127:0] d);
    int g = 0;
    while (!w_ready && g < 5000) begin
      tick();
      g++;
    end
    if (g == 5000) chk("wr_ready_timeout", 32'(w_ready), 1);
    w_valid = 1'b1;
    w_col   = 4'(col);
    w_row   = 3'(row);
    w_data  = d;
    tick();
    w_valid = 1'b0;
  endtask

  task automatic do_write(input int col, input int row, input logic [127:0] d);
    int n;
    start_write(col, row, d);
    wait_idle(n);
    chk("wr_busy", 32'(n), 16);
  endtask

  task automatic do_scroll;
    int n;
    scroll_req = 1'b1;
    tick();
    scroll_req = 1'b0;
    wait_idle(n);
    chk("scroll_busy", 32'(n), ROWW);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int           n;
    logic [127:0] d;
    logic [1:0]   res;
    logic         early;

    // Reset state and auto-clear length
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 1);
    chk("rst_ready", 32'(w_ready), 0);
    chk("rst_out", {30'd0, out_valid, out}, 0);
    rst_n = 1'b1;
    wait_idle(n);
    chk("autoclr_len", 32'(n), TOT);
    chk("autoclr_ready", 32'(w_ready), 1);
    read_px(10, 20, res, early);
    chk("rd_early", 32'(early), 0);
    chk("rd_reset_px", 32'(res), 32'b10);

    // Diagonal glyph at column 5, row 2
    for (int k = 0; k < 16; k++) d[k*8 +: 8] = 8'h01 << (k % 8);
    do_write(5, 2, d);
    for (int y = 32; y < 48; y++)
      for (int x = 40; x < 48; x++)
        px("glyph_px", x, y, (x - 40) == ((y - 32) % 8));
    px("glyph_left", 39, 32, 1'b0);
    px("glyph_right", 48, 32, 1'b0);

    // Clear to 0xFF with a write held pending throughout
    clr_val = 8'hFF;
    clr_req = 1'b1;
    w_valid = 1'b1;
    w_col   = 4'd0;
    w_row   = 3'd0;
    w_data  = '1;
    tick();
    clr_req = 1'b0;
    clr_val = 8'h00;
    n = 0;
    while (!w_ready && n < 5000) begin
      tick();
      n++;
    end
    chk("clr_wait", 32'(n), TOT);
    tick();
    w_valid = 1'b0;
    wait_idle(n);
    chk("clr_wr_busy", 32'(n), 16);
    px("clr_p0", 0, 0, 1'b1);
    px("clr_p1", 95, 79, 1'b1);
    px("clr_p2", 44, 36, 1'b1);
    px("clr_p3", 47, 40, 1'b1);
    px("rd_oor_x", 100, 0, 1'b0);
    px("rd_oor_y", 0, 90, 1'b0);

    // Rows 0/1 filled with AA/55, then one scroll
    for (int c = 0; c < 12; c++) begin
      do_write(c, 0, glyph(8'hAA));
      do_write(c, 1, glyph(8'h55));
    end
    px("pre_scroll", 1, 0, 1'b1);
    do_scroll();
    px("scr_55_x0", 0, 0, 1'b1);
    px("scr_55_x1", 1, 0, 1'b0);
    px("scr_55_x94", 94, 15, 1'b1);
    px("scr_55_x95", 95, 15, 1'b0);
    px("scr_row1", 1, 16, 1'b1);
    px("scr_bot0", 0, 64, 1'b0);
    px("scr_bot1", 95, 79, 1'b0);
    px("scr_bot2", 50, 70, 1'b0);

    // Marker at logical row 4 (physical 0), then wrap the row pointer
    do_write(0, 4, glyph(8'hFF));
    do_scroll();
    do_scroll();
    do_scroll();
    px("top4_mark", 0, 16, 1'b1);
    px("top4_zero", 8, 16, 1'b0);
    do_scroll();
    px("wrap_mark0", 0, 0, 1'b1);
    px("wrap_mark1", 7, 15, 1'b1);
    px("wrap_col1", 8, 0, 1'b0);
    px("wrap_row1", 0, 16, 1'b0);
    px("wrap_row4", 0, 64, 1'b0);

    // Two scroll pulses during a write collapse to one scroll
    start_write(3, 2, glyph(8'hFF));
    tick();
    scroll_req = 1'b1;
    tick();
    scroll_req = 1'b0;
    tick();
    scroll_req = 1'b1;
    tick();
    scroll_req = 1'b0;
    wait_idle(n);
    chk("wr2_rest", 32'(n), 12);
    chk("wr2_pend_ready", 32'(w_ready), 0);
    tick();
    chk("pend_scroll_busy", 32'(busy), 1);
    wait_idle(n);
    chk("pend_scroll_len", 32'(n), ROWW);
    tick();
    chk("single_scroll", 32'(busy), 0);
    chk("single_ready", 32'(w_ready), 1);
    px("moved_glyph0", 24, 16, 1'b1);
    px("moved_glyph1", 31, 31, 1'b1);
    px("moved_below", 24, 32, 1'b0);
    px("scrolled_out", 0, 64, 1'b0);

    // Out-of-range writes change nothing
    do_write(12, 0, glyph(8'hFF));
    px("oor_col_a", 0, 1, 1'b0);
    px("oor_col_b", 0, 16, 1'b0);
    do_write(0, 7, glyph(8'hFF));
    px("oor_row", 0, 32, 1'b0);

    // Reset in the middle of a write with a read in flight
    start_write(0, 0, glyph(8'hFF));
    tick();
    rd  = 1'b1;
    r_x = 7'd24;
    r_y = 7'd16;
    tick();
    rd    = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 1);
    chk("mid_rst_ready", 32'(w_ready), 0);
    chk("mid_rst_out", {30'd0, out_valid, out}, 0);
    tick();
    rst_n = 1'b1;
    wait_idle(n);
    chk("mid_rst_autoclr", 32'(n), TOT);
    px("mid_rst_px0", 24, 16, 1'b0);
    px("mid_rst_px1", 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_cell_fb.md
# vga_cell_fb

Parametrised character-cell framebuffer for the VGA path: successor to the fixed 640x480 / 8x16 text RAM. The host writes one glyph bitmap per text cell through a valid/ready port. The glyph is committed one pixel line per cycle. The scan-out side reads individual pixels with a fixed 2-cycle latency. Adds hardware clear, hardware one-row scroll (circular row pointer) and an automatic clear after reset.

## Interface
- H_RES, 640, visible pixels per line; must be a multiple of CELL_W
- V_RES, 480, visible lines; must be a multiple of CELL_H
- CELL_W, 8, glyph width in pixels (bits per memory word)
- CELL_H, 16, glyph height in pixel lines
- Derived, not overridable: W_COLS=H_RES/CELL_W; W_ROWS=V_RES/CELL_H; CW=$clog2(W_COLS); RW=$clog2(W_ROWS); XW=$clog2(H_RES); YW=$clog2(V_RES)
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- w_valid  in  1  glyph write request
- w_ready  out  1  high only in IDLE with no clr_req/scroll_req pending; transfer when w_valid&&w_ready
- w_data  in  CELL_W*CELL_H  glyph; line k = w_data[k*CELL_W +: CELL_W], k=0 is top
- w_col  in  CW  text column
- w_row  in  RW  logical text row (0 = top of screen)
- clr_req  in  1  single-cycle pulse: fill whole memory with clr_val
- clr_val  in  CELL_W  fill word, sampled when clear starts
- scroll_req  in  1  single-cycle pulse: scroll up one text row, new bottom row blank
- busy  out  1  high in any state other than IDLE
- rd  in  1  pixel read request
- r_x  in  XW  pixel column
- r_y  in  YW  pixel line
- out  out  1  pixel value
- out_valid  out  1  qualifies out, 2 cycles after rd

## Operation
- Storage: V_RES*W_COLS words of CELL_W bits, one write port and one read port. Pixel x of a word is bit x%CELL_W; bit 0 is leftmost.
- Row mapping: register top_row (RW bits). Logical text row t maps to physical row (t+top_row) mod W_ROWS. The mapping applies to both write and read (read uses r_y/CELL_H).
- FSM states: IDLE, WRITE, CLEAR, SCROLL.
- IDLE:
  - Priority is clear > scroll > write.
  - clr_req -> CLEAR. scroll_req -> SCROLL. Otherwise an accepted write -> WRITE.
  - Write fields (data, column, physical row) are latched at acceptance.
- WRITE: line counter 0..CELL_H-1; writes line k at address (phys_row*CELL_H+k, w_col). After line CELL_H-1 -> IDLE.
- CLEAR: address counter 0..V_RES*W_COLS-1 writes clr_val; top_row<=0 on the last cycle; -> IDLE.
- SCROLL: writes 0 to all CELL_H*W_COLS words of physical row top_row (the old top row becomes the new bottom row). On the last cycle top_row<=(top_row+1) mod W_ROWS (wrap W_ROWS-1 -> 0); -> IDLE.
- Requests pulsed while busy: clr_req is latched into one pending flag and serviced on return to IDLE. scroll_req likewise, into one pending flag (multiple pulses collapse to one). Pending clear discards a pending scroll.
- Out of range: a write with w_col>=W_COLS or w_row>=W_ROWS is accepted and takes CELL_H cycles, but performs no memory writes. A read with r_x>=H_RES or r_y>=V_RES returns out=0 with out_valid=1.
- Read/write collision on the same word in the same cycle: read returns the old data (read-first).

## Timing
- Reset values: state=CLEAR with clr_val forced to 0 (auto-clear); busy=1, w_ready=0, out=0, out_valid=0, top_row=0, pending flags=0.
- After rst_n rises, busy stays high for exactly V_RES*W_COLS cycles, then w_ready=1.
- rst_n asserted mid-operation aborts immediately. Partially written memory is overwritten by the auto-clear.
- Write: accept at cycle 0; memory lines written in cycles 1..CELL_H; busy high cycles 1..CELL_H; w_ready back high in cycle CELL_H+1.
- Clear and scroll take V_RES*W_COLS and CELL_H*W_COLS cycles respectively, starting the cycle after the request is seen in IDLE.
- Read pipeline:
  - Stage 1: compute address and register the word and the bit index.
  - Stage 2: register out.
  - out_valid=rd delayed by 2 cycles. Fully pipelined: one pixel per cycle regardless of FSM state.
- Reads during SCROLL use the old top_row until the last scroll cycle.

## Test plan
- Reset release, defaults: busy high for 38400 cycles, then w_ready=1. Read any pixel -> out=0, out_valid 2 cycles after rd.
- Write w_col=5, w_row=2, line k=8'h01<<(k%8). Scan rows 32..47, cols 40..47 -> pixel (40+k%8, 32+k) =1, others 0. w_ready low 16 cycles.
- clr_req with clr_val=8'hFF, then a write with w_valid held during clear. Required: all pixels 1; the write is accepted only after 38400 cycles.
- Scroll:
  - Fill row 0 with 8'hAA and row 1 with 8'h55, then scroll_req.
  - Required: busy for 1280 cycles; pixel line 0 shows the 0x55 pattern; lines 464..479 read 0.
- Scroll 30 times: top_row wraps to 0 and the original mapping is restored. Two scroll_req pulses during a write -> exactly one scroll.
- Write w_col=80 (out of range): no memory change, 16 busy cycles. rst_n low mid-WRITE: outputs return to reset values, then a 38400-cycle auto-clear.
